// File: rtl/calc_cmd_scheduler_pkg.sv
// Shared constants for the calculator command scheduler: calculator status
// codes, key command codes and scheduler state encodings.
package calc_cmd_scheduler_pkg;

    // Calculator status as reported on calc_status
    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    // Operator / control key codes (digits are 4'h0..4'h9)
    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_BKSP = 4'hF;

    // Scheduler states
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t S_IDLE     = 2'd0;
    localparam sched_state_t S_GAP      = 2'd1;
    localparam sched_state_t S_WAIT_RES = 2'd2;
    localparam sched_state_t S_ERROR    = 2'd3;

    // The equals key terminates an expression and starts a result wait
    function automatic logic is_eq(input logic [3:0] code);
        return code == CMD_EQ;
    endfunction

endpackage

// File: rtl/calc_cmd_scheduler_if.sv
// Handshake and calculator-side bundle of the command scheduler.
// master: requesters + calculator model side; slave: the scheduler.
interface calc_cmd_scheduler_if;
    logic [3:0] req0_cmd;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req1_cmd;
    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] calc_status;
    logic [3:0] calc_cmd;
    logic       calc_cmd_valid;
    logic       owner;
    logic       locked;
    logic       err;
    logic       timeout;

    modport master (
        output req0_cmd, req0_valid, req1_cmd, req1_valid, calc_status,
        input  req0_ready, req1_ready, calc_cmd, calc_cmd_valid,
               owner, locked, err, timeout
    );

    modport slave (
        input  req0_cmd, req0_valid, req1_cmd, req1_valid, calc_status,
        output req0_ready, req1_ready, calc_cmd, calc_cmd_valid,
               owner, locked, err, timeout
    );
endinterface

// File: rtl/calc_cmd_scheduler_cmd_fifo.sv
// Small command FIFO with show-ahead head output. A pop frees its slot in
// the same cycle, so push+pop on a full FIFO is accepted.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array: written on accepted push, contents need no reset
    always_ff @(posedge i_clock) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/calc_cmd_scheduler.sv
// Shares the calculator command input between keypad (req0) and serial
// (req1). Ownership is locked per expression, codes are queued and issued
// as one-cycle strobes while the calculator is ready, with an inter-issue
// gap, a result-wait timeout and a sticky error state.
module calc_cmd_scheduler
    import calc_cmd_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    calc_cmd_scheduler_if.slave bus
);
    localparam int              WW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WW-1:0]   TO_VAL   = WW'(BUSY_TIMEOUT);
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

    sched_state_t  r_state;
    logic [3:0]    r_gap_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic [3:0]    r_cmd;
    logic          r_last_eq;
    logic          r_err;
    logic          r_timeout;
    logic          r_owner;
    logic          r_locked;
    logic          r_rr;

    logic [3:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_can;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_push;
    logic [3:0]    w_push_cmd;
    logic          w_flush;

    // Requester may push when the queue has room and we are not in ERROR.
    // While unlocked, a requester is grantable unless the other one is also
    // valid and the round-robin pointer favours the other.
    assign w_can      = !reset && (r_state != S_ERROR) && !w_full;
    assign w_ready0   = w_can && (r_locked ? !r_owner : (!bus.req1_valid || !r_rr));
    assign w_ready1   = w_can && (r_locked ?  r_owner : (!bus.req0_valid ||  r_rr));
    assign w_acc0     = bus.req0_valid && w_ready0;
    assign w_acc1     = bus.req1_valid && w_ready1;
    assign w_push     = w_acc0 || w_acc1;
    assign w_push_cmd = w_acc1 ? bus.req1_cmd : bus.req0_cmd;
    assign w_flush    = (r_state == S_ERROR);

    // Issue only from IDLE with a queued code and a ready calculator; an
    // error status is never READY, so it suppresses the strobe by itself.
    assign w_issue = (r_state == S_IDLE) && !w_empty && (bus.calc_status == ST_READY);

    assign bus.req0_ready     = w_ready0;
    assign bus.req1_ready     = w_ready1;
    assign bus.calc_cmd       = w_issue ? w_head : r_cmd;
    assign bus.calc_cmd_valid = w_issue;
    assign bus.owner          = r_owner;
    assign bus.locked         = r_locked && (r_state != S_ERROR);
    assign bus.err            = r_err;
    assign bus.timeout        = r_timeout;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (4)
    ) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_flush (w_flush),
        .i_din   (w_push_cmd),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ownership: grant on first accepted code, release on accepted equals
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner  <= 1'b0;
            r_locked <= 1'b0;
            r_rr     <= 1'b0;
        end else if (r_state == S_ERROR) begin
            r_locked <= 1'b0;
        end else if (w_push) begin
            if (!r_locked) begin
                r_owner <= w_acc1;
                if (bus.req0_valid && bus.req1_valid) r_rr <= ~r_rr;
            end
            r_locked <= !is_eq(w_push_cmd);
        end
    end

    // Issue sequencing: IDLE -> GAP -> (WAIT_RES after equals) -> IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= '0;
            r_wait_cnt <= '0;
            r_cmd      <= '0;
            r_last_eq  <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (bus.calc_status == ST_ERR) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cmd     <= w_head;
                        r_last_eq <= is_eq(w_head);
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= r_last_eq ? S_WAIT_RES : S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_WAIT_RES: begin
                    if ((r_wait_cnt != '0) && (bus.calc_status == ST_READY)) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt >= TO_VAL) begin
                        r_timeout <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= S_ERROR;
            endcase
        end
    end
endmodule
